// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the two-requester ALU arbiter.
// Op codes and FSM state encoding.
package alu_arbiter_pkg;

  typedef enum logic [2:0] {
    OP_AND   = 3'b000,
    OP_OR    = 3'b001,
    OP_ADD   = 3'b010,
    OP_XOR   = 3'b011,
    OP_SHL16 = 3'b100,
    OP_ILL   = 3'b101,
    OP_SUB   = 3'b110,
    OP_ZERO  = 3'b111
  } op_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  function automatic logic op_illegal(input op_t op);
    return op == OP_ILL;
  endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// Request/response bundle between requesters and the arbiter.
// master = requester side, slave = arbiter side.
interface alu_arbiter_if #(parameter int DW = 32);
  logic [1:0]    req_valid;
  logic [1:0]    req_ready;
  logic [DW-1:0] req0_a;
  logic [DW-1:0] req0_b;
  logic [2:0]    req0_op;
  logic [DW-1:0] req1_a;
  logic [DW-1:0] req1_b;
  logic [2:0]    req1_op;
  logic [1:0]    rsp_valid;
  logic [1:0]    rsp_ready;
  logic [DW-1:0] rsp_data;
  logic          rsp_zero;
  logic          rsp_ovf;
  logic          rsp_err;

  modport master (
    output req_valid, req0_a, req0_b, req0_op,
    output req1_a, req1_b, req1_op, rsp_ready,
    input  req_ready, rsp_valid, rsp_data,
    input  rsp_zero, rsp_ovf, rsp_err
  );

  modport slave (
    input  req_valid, req0_a, req0_b, req0_op,
    input  req1_a, req1_b, req1_op, rsp_ready,
    output req_ready, rsp_valid, rsp_data,
    output rsp_zero, rsp_ovf, rsp_err
  );
endinterface

// File: rtl/alu_arbiter_rr_grant2.sv
// Two-way round-robin pick with last-grant memory.
// Last grant resets to 1 so the first tie goes to requester 0.
module rr_grant2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       take,
  output logic [1:0] gnt,
  output logic       idx
);

  logic last;

  always_comb begin
    idx = (req == 2'b11) ? ~last : req[1];
    gnt = 2'b00;
    if (req != 2'b00)
      gnt = idx ? 2'b10 : 2'b01;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      last <= 1'b1;
    else if (take)
      last <= idx;
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one external combinational ALU between two requesters.
// Accept in IDLE, drive ALU in EXEC, hold response in RESP.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  alu_arbiter_if.slave  bus,
  output logic [DW-1:0] alu_a,
  output logic [DW-1:0] alu_b,
  output logic [2:0]    alu_aluc,
  input  logic [DW-1:0] alu_out,
  input  logic          alu_overflow,
  output logic          busy
);

  state_t        state, state_n;
  logic [1:0]    gnt;
  logic          gidx;
  logic          cur;
  logic          take;
  logic [DW-1:0] op_a;
  logic [DW-1:0] op_b;
  op_t           op_c;

  assign take = (state == S_IDLE) && (bus.req_valid != 2'b00);

  rr_grant2 u_rr (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (bus.req_valid),
    .take  (take),
    .gnt   (gnt),
    .idx   (gidx)
  );

  // Gated by rst_n so the strobe is dead while reset is held.
  assign bus.req_ready =
    (state == S_IDLE && rst_n) ? gnt : 2'b00;
  assign bus.rsp_valid =
    (state == S_RESP) ? (cur ? 2'b10 : 2'b01) : 2'b00;
  assign busy = (state != S_IDLE);

  always_comb begin
    state_n  = state;
    alu_a    = '0;
    alu_b    = '0;
    alu_aluc = OP_ZERO;
    unique case (1'b1)
      (state == S_IDLE): begin
        if (bus.req_valid != 2'b00)
          state_n = S_EXEC;
      end
      (state == S_EXEC): begin
        alu_a    = op_a;
        alu_b    = op_b;
        alu_aluc = op_illegal(op_c) ? OP_ZERO : op_c;
        state_n  = S_RESP;
      end
      (state == S_RESP): begin
        if (bus.rsp_ready[cur])
          state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      cur          <= 1'b0;
      op_a         <= '0;
      op_b         <= '0;
      op_c         <= OP_ZERO;
      bus.rsp_data <= '0;
      bus.rsp_zero <= 1'b0;
      bus.rsp_ovf  <= 1'b0;
      bus.rsp_err  <= 1'b0;
    end else begin
      state <= state_n;
      if (take) begin
        cur  <= gidx;
        op_a <= gidx ? bus.req1_a : bus.req0_a;
        op_b <= gidx ? bus.req1_b : bus.req0_b;
        op_c <= op_t'(gidx ? bus.req1_op : bus.req0_op);
      end
      if (state == S_EXEC) begin
        if (op_illegal(op_c)) begin
          bus.rsp_data <= '0;
          bus.rsp_zero <= 1'b1;
          bus.rsp_ovf  <= 1'b0;
          bus.rsp_err  <= 1'b1;
        end else begin
          bus.rsp_data <= alu_out;
          bus.rsp_zero <= (alu_out == '0);
          bus.rsp_ovf  <= alu_overflow;
          bus.rsp_err  <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Randomized self-checking bench for alu_arbiter.
// Includes a behavioural ALU and a high-level reference model.
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] alu_a, alu_b, alu_out;
  logic [2:0]  alu_aluc;
  logic        alu_ovf;
  logic        busy;

  logic [1:0]  v;
  logic [1:0]  rdy;
  logic [31:0] a [2];
  logic [31:0] b [2];
  logic [2:0]  op [2];

  int total = 0;
  int bad = 0;
  int last_g = 1;

  always #5 clk = ~clk;

  alu_arbiter_if #(.DW(32)) bus ();

  assign bus.req_valid = v;
  assign bus.rsp_ready = rdy;
  assign bus.req0_a = a[0];
  assign bus.req0_b = b[0];
  assign bus.req0_op = op[0];
  assign bus.req1_a = a[1];
  assign bus.req1_b = b[1];
  assign bus.req1_op = op[1];

  alu_arbiter #(.DW(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_aluc     (alu_aluc),
    .alu_out      (alu_out),
    .alu_overflow (alu_ovf),
    .busy         (busy)
  );

  always_comb begin
    alu_out = '0;
    alu_ovf = 1'b0;
    case (alu_aluc)
      3'b010: begin
        alu_out = alu_a + alu_b;
        alu_ovf = (alu_a[31] == alu_b[31]) &&
                  (alu_out[31] != alu_a[31]);
      end
      3'b110: begin
        alu_out = alu_a - alu_b;
        alu_ovf = (alu_a[31] != alu_b[31]) &&
                  (alu_out[31] != alu_a[31]);
      end
      3'b000: alu_out = alu_a & alu_b;
      3'b001: alu_out = alu_a | alu_b;
      3'b011: alu_out = alu_a ^ alu_b;
      3'b100: alu_out = {alu_a[15:0], 16'h0};
      default: alu_out = '0;
    endcase
  end

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic void model(input logic [31:0] x,
                                input logic [31:0] y,
                                input logic [2:0] o,
                                output logic [31:0] d,
                                output logic ovf,
                                output logic err);
    longint s;
    d = '0;
    ovf = 1'b0;
    err = 1'b0;
    s = 0;
    case (o)
      3'b010: s = longint'($signed(x)) + longint'($signed(y));
      3'b110: s = longint'($signed(x)) - longint'($signed(y));
      default: s = 0;
    endcase
    case (o)
      3'b010, 3'b110: begin
        d = 32'(s);
        ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      3'b000: d = x & y;
      3'b001: d = x | y;
      3'b011: d = x ^ y;
      3'b100: d = 32'(longint'(x) * 65536);
      3'b101: err = 1'b1;
      default: d = '0;
    endcase
  endfunction

  task automatic chk_rsp(input string tag, input logic [1:0] oh,
                         input logic [31:0] ed, input logic eo,
                         input logic ee);
    chk({tag, "_valid"}, bus.rsp_valid, oh);
    chk({tag, "_data"}, bus.rsp_data, ed);
    chk({tag, "_zero"}, bus.rsp_zero, ed == 0);
    chk({tag, "_ovf"}, bus.rsp_ovf, eo);
    chk({tag, "_err"}, bus.rsp_err, ee);
  endtask

  // Call at negedge in IDLE with v already driven.
  task automatic serve(input int hold);
    int g;
    logic [1:0]  oh;
    logic [31:0] ed, ea, eb;
    logic        eo, ee;
    logic [2:0]  eop;
    g = (v == 2'b11) ? (1 - last_g) : (v[1] ? 1 : 0);
    oh = (g == 1) ? 2'b10 : 2'b01;
    #1;
    chk("req_ready", bus.req_ready, oh);
    chk("idle_busy", busy, 0);
    model(a[g], b[g], op[g], ed, eo, ee);
    ea = a[g];
    eb = b[g];
    eop = (op[g] == 3'b101) ? 3'b111 : op[g];
    last_g = g;
    @(posedge clk);
    @(negedge clk);
    v[g] = 1'b0;
    #1;
    chk("exec_busy", busy, 1);
    chk("exec_ready", bus.req_ready, 0);
    chk("exec_valid", bus.rsp_valid, 0);
    chk("exec_a", alu_a, ea);
    chk("exec_b", alu_b, eb);
    chk("exec_aluc", alu_aluc, eop);
    @(negedge clk);
    #1;
    chk_rsp("resp", oh, ed, eo, ee);
    chk("resp_aluc", alu_aluc, 3'b111);
    chk("resp_a", alu_a, 0);
    for (int i = 0; i < hold; i++) begin
      rdy = ~oh;
      @(negedge clk);
      #1;
      chk_rsp("hold", oh, ed, eo, ee);
      chk("hold_ready", bus.req_ready, 0);
      chk("hold_busy", busy, 1);
    end
    rdy = oh;
    @(negedge clk);
    rdy = 2'b00;
    #1;
    chk("done_valid", bus.rsp_valid, 0);
    chk("done_busy", busy, 0);
  endtask

  task automatic set_req(input int i, input logic [31:0] x,
                         input logic [31:0] y,
                         input logic [2:0] o);
    v[i] = 1'b1;
    a[i] = x;
    b[i] = y;
    op[i] = o;
  endtask

  task automatic chk_reset_vals();
    chk("rst_ready", bus.req_ready, 0);
    chk("rst_valid", bus.rsp_valid, 0);
    chk("rst_data", bus.rsp_data, 0);
    chk("rst_zero", bus.rsp_zero, 0);
    chk("rst_ovf", bus.rsp_ovf, 0);
    chk("rst_err", bus.rsp_err, 0);
    chk("rst_a", alu_a, 0);
    chk("rst_b", alu_b, 0);
    chk("rst_aluc", alu_aluc, 3'b111);
    chk("rst_busy", busy, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    v = 2'b00;
    rdy = 2'b00;
    for (int i = 0; i < 2; i++) begin
      a[i] = '0;
      b[i] = '0;
      op[i] = 3'b111;
    end
    #3;
    chk_reset_vals();
    set_req(0, 32'd5, 32'd5, 3'b110);
    set_req(1, 32'hF0, 32'h0F, 3'b001);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    serve(0);
    serve(10);

    set_req(0, 32'h7FFF_FFFF, 32'h1, 3'b010);
    serve(0);
    set_req(0, 32'h0000_1234, 32'h0, 3'b100);
    serve(1);
    set_req(1, 32'h1234_5678, 32'h9, 3'b101);
    serve(2);

    set_req(0, 32'h11, 32'h22, 3'b010);
    #1;
    chk("pre_rst_ready", bus.req_ready, 2'b01);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_vals();
    last_g = 1;
    v = 2'b00;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1;
      chk("post_rst_valid", bus.rsp_valid, 0);
      chk("post_rst_busy", busy, 0);
    end

    set_req(0, 32'hFFFF_FFFF, 32'h1, 3'b010);
    set_req(1, 32'h8000_0000, 32'h1, 3'b110);
    serve(0);
    serve(0);

    for (int n = 0; n < 60; n++) begin
      for (int i = 0; i < 2; i++) begin
        if (!v[i] && $urandom_range(0, 1) == 1) begin
          v[i] = 1'b1;
          a[i] = ($urandom_range(0, 3) == 0) ? 32'h7FFF_FFFF
                                             : $urandom;
          b[i] = ($urandom_range(0, 3) == 0) ? a[i] : $urandom;
          op[i] = 3'($urandom_range(0, 7));
        end
      end
      if (v == 2'b00)
        set_req(0, $urandom, $urandom, 3'b010);
      serve(int'($urandom_range(0, 3)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: DW, default 32, datapath width of operands and result.
REQ-002 Clock and reset: one clock; reset is asynchronous and active-low.
REQ-003 Port: clk  in  1  rising-edge clock for all state.
REQ-004 Port: rst_n  in  1  asynchronous active-low reset.
REQ-005 Port: req_valid  in  2  per-requester operation request; bit i = requester i.
REQ-006 Port: req_ready  out  2  one-cycle accept strobe to requester i.
REQ-007 Port: req0_a, req0_b  in  DW each  requester 0 operands.
REQ-008 Port: req0_op  in  3  requester 0 ALU op code.
REQ-009 Port: req1_a, req1_b, req1_op  in  DW, DW, 3  requester 1 operands and op code.
REQ-010 Port: rsp_valid  out  2  result valid for requester i; at most one bit set.
REQ-011 Port: rsp_ready  in  2  requester i consumes result.
REQ-012 Port: rsp_data  out  DW  registered result.
REQ-013 Port: rsp_zero, rsp_ovf, rsp_err  out  1 each  result==0, signed overflow, illegal op.
REQ-014 Port: alu_a, alu_b  out  DW each  operands to the shared combinational ALU.
REQ-015 Port: alu_aluc  out  3  op code to the shared ALU.
REQ-016 Port: alu_out  in  DW  ALU result; alu_overflow  in  1  ALU overflow.
REQ-017 Port: busy  out  1  high in any state other than IDLE.

Function
REQ-018 Op codes SHALL be: 010 add, 110 sub, 000 and, 001 or, 011 xor, 100 shift-left-16, 111 zero; 101 is illegal.
REQ-019 FSM states SHALL be IDLE, EXEC and RESP.
REQ-020 In IDLE with any req_valid set, the block SHALL grant one requester, pulse req_ready for it that cycle, latch its a, b and op, and go to EXEC.
REQ-021 If both requesters are valid, the grant SHALL go to the requester not equal to last_grant.
REQ-022 last_grant SHALL update to the granted index on every grant.
REQ-023 In EXEC, alu_a, alu_b and alu_aluc SHALL be driven from the latched operands for exactly one cycle.
REQ-024 At the end of EXEC, the block SHALL capture alu_out into rsp_data and alu_overflow into rsp_ovf, then go to RESP.
REQ-025 rsp_zero SHALL be computed by the arbiter as (captured rsp_data == 0); the ALU zero flag is not used.
REQ-026 For illegal op 101, EXEC SHALL drive alu_aluc=111 and capture rsp_data=0, rsp_ovf=0, rsp_err=1; otherwise rsp_err=0.
REQ-027 In RESP, rsp_valid[grant] SHALL stay high with rsp_data and all flags stable until rsp_ready[grant] is high.
REQ-028 On rsp_ready[grant] in RESP, the block SHALL return to IDLE.
REQ-029 rsp_ready on the non-granted bit SHALL be ignored.
REQ-030 Latency SHALL be: request accepted in cycle N, rsp_valid high in cycle N+2; throughput is at most one op per 3 cycles.
REQ-031 Outside EXEC, alu_aluc SHALL be 111 and alu_a and alu_b SHALL be 0.
REQ-032 Requests arriving in EXEC or RESP SHALL NOT receive req_ready; requesters hold them until IDLE.

Reset
REQ-033 Asserting rst_n low SHALL immediately set: state IDLE, last_grant=1, req_ready=0, rsp_valid=0, rsp_data=0, rsp_zero/rsp_ovf/rsp_err=0, alu_a/alu_b=0, alu_aluc=111, busy=0.
REQ-034 Reset mid-transaction SHALL discard the transaction with no response.
REQ-035 After reset release, the first contended grant SHALL go to requester 0.

Structure
REQ-036 A shared package SHALL hold the op-code constants and the FSM state encoding.
REQ-037 One sub-module, rr_grant2, SHALL hold the two-way round-robin pick and the last_grant register.

Verification
REQ-038 Single add: req0 add 0x7FFFFFFF+1 -> rsp_valid[0] at N+2, rsp_data=0x80000000, rsp_ovf=1, rsp_zero=0.
REQ-039 Contention: both requesters valid from reset (req0 sub 5-5, req1 or 0xF0|0x0F) -> req0 first with rsp_data=0, rsp_zero=1; then req1 with rsp_data=0xFF.
REQ-040 Backpressure: rsp_ready[1] held low 10 cycles -> rsp_valid[1], rsp_data and flags stable, no new req_ready, busy=1.
REQ-041 Illegal op 101 from req1 -> alu_aluc=111 in EXEC, rsp_data=0, rsp_err=1, rsp_ovf=0.
REQ-042 Reset mid-op: rst_n low during EXEC -> all outputs at reset values asynchronously, no rsp_valid after release.
REQ-043 Shift: req0 op 100, a=0x00001234 -> rsp_data=0x12340000, rsp_ovf=0.
